golden_nonce_uart_tx: RTL and testbench
=======================================

// Module: golden_nonce_uart_tx
// PURPOSE
//  Return path from hasher to host. Queues golden nonces from the miner control unit
//  (one-cycle strobe + 32-bit nonce) in a small FIFO and sends each one over a UART line.
//  Serial format is 8N1, four bytes per nonce, MSB byte first. Sits beside the hasher
//  pipeline on the hash clock. Replaces the JTAG probe readout for boards without JTAG.
// PARAMETERS
//  BAUD_DIV    868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_AW     2    FIFO address width; depth = 2**FIFO_AW nonces
// PORTS
//  clk          in   1        hash clock; all logic on rising edge
//  reset        in   1        asynchronous, active-high reset
//  nonce_valid  in   1        one-cycle strobe: nonce_in is a golden nonce
//  nonce_in     in   32       nonce captured on the edge where nonce_valid=1
//  uart_tx      out  1        serial line, idle high
//  busy         out  1        1 while a nonce frame is being shifted out
//  fifo_count   out  FIFO_AW+1  number of nonces queued, not counting the one in flight
//  overflow     out  1        sticky: a nonce was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): uart_tx=1, busy=0, fifo_count=0, overflow=0.
//   FIFO is emptied and the FSM goes to IDLE immediately, even in mid-byte. No partial
//   byte is completed.
//  FIFO: push on nonce_valid when count < depth, or when a pop happens on the same edge.
//   If neither holds, the nonce is dropped and overflow is set; only reset clears overflow.
//   Pointers wrap modulo depth. fifo_count is registered and updates on the same edge as
//   the push or pop.
//  FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//   IDLE: uart_tx=1. If count>0: pop head into 32-bit shift reg, byte_idx=0, go to START,
//    busy=1.
//   START: uart_tx=0 for BAUD_DIV cycles.
//   DATA: 8 bits of the current byte, LSB first, BAUD_DIV cycles each.
//    Byte order: nonce[31:24], [23:16], [15:8], [7:0].
//   STOP: uart_tx=1 for BAUD_DIV cycles. Then if byte_idx<3: byte_idx++, go to START.
//    Otherwise go to IDLE and clear busy.
//  No idle gap between bytes of one nonce. Back-to-back nonces get exactly one extra clk
//   of idle (the IDLE pop cycle).
//  Latency: a strobe captured on edge E with the FIFO empty and FSM idle is popped at E+1.
//   uart_tx falls at E+2. busy rises at E+2 and falls 40*BAUD_DIV cycles after uart_tx fell.
//  Bit timer: counter 0..BAUD_DIV-1, reloads at each bit boundary. Bit counter 0..7.
//   byte_idx 0..3. All outputs are registered. uart_tx is glitch-free.
//  A push arriving while a frame is in flight does not disturb that frame.
//  Simultaneous push and pop with the FIFO full: both take effect and count stays at depth.
// TESTING
//  (bench: BAUD_DIV=4, FIFO_AW=2)
//  1 Single nonce 32'hA1B2C3D4 into idle block:
//    uart_tx low 2 clk after the strobe edge.
//    Decoded bytes A1,B2,C3,D4 with start=0 and stop=1.
//    busy high exactly 160 clk.
//  2 Three strobes on consecutive cycles (11111111, 22222222, 33333333):
//    fifo_count reaches 2.
//    12 bytes arrive in order.
//    Exactly 1 idle clk between frames.
//    overflow stays 0.
//  3 Six strobes back-to-back while idle:
//    first is popped; the next four fill the FIFO; the sixth is dropped.
//    overflow=1 and stays 1 until reset.
//    Exactly 5 nonces are transmitted.
//  4 Strobe on the same edge as the IDLE pop with the FIFO full:
//    push accepted, fifo_count stays 4, overflow stays 0.
//  5 Assert reset during the DATA bits of byte 2:
//    uart_tx=1 asynchronously.
//    busy=0, fifo_count=0, overflow=0.
//    After release, a new nonce 32'h00000001 transmits cleanly.
//  6 nonce_valid held low for 1000 clk after reset:
//    uart_tx constantly 1, busy 0.

Source files
------------

// File: rtl/golden_nonce_uart_tx_if.sv
// ============================================================================
// Module   : golden_nonce_uart_tx_if
// Brief    : Nonce strobe input and UART/status outputs of golden_nonce_uart_tx
// Revision : 1.0
// ============================================================================
`default_nettype none

interface golden_nonce_uart_tx_if #(
    parameter int FIFO_AW = 2
);
    logic               nonce_valid;
    logic [31:0]        nonce_in;
    logic               uart_tx;
    logic               busy;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;

    modport master (
        output nonce_valid, nonce_in,
        input  uart_tx, busy, fifo_count, overflow
    );

    modport slave (
        input  nonce_valid, nonce_in,
        output uart_tx, busy, fifo_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/golden_nonce_uart_tx.sv
// ============================================================================
// Module   : golden_nonce_uart_tx
// Brief    : Queues golden nonces in a FIFO and sends each as four 8N1 bytes
// Revision : 1.0
// ============================================================================
`default_nettype none

module golden_nonce_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    golden_nonce_uart_tx_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [TW-1:0]      r_timer, w_timer_n;
    logic [2:0]         r_bit, w_bit_n;
    logic [1:0]         r_byte_idx, w_byte_idx_n;
    logic [31:0]        r_shift, w_shift_n;
    logic               r_tx, w_tx;
    logic               r_busy;
    logic [31:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic w_pop, w_push, w_full, w_bit_end;

    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_full    = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_push    = bus.nonce_valid && (!w_full || w_pop);
    assign w_bit_end = (r_timer == TW'(BAUD_DIV - 1));

    always_comb begin
        w_state_n    = r_state;
        w_timer_n    = r_timer + 1'b1;
        w_bit_n      = r_bit;
        w_byte_idx_n = r_byte_idx;
        w_shift_n    = r_shift;
        w_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                if (w_pop) begin
                    w_state_n    = S_START;
                    w_bit_n      = 3'd0;
                    w_byte_idx_n = 2'd0;
                    w_shift_n    = r_mem[r_rptr];
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_timer_n = '0;
                    w_bit_n   = 3'd0;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                // Current byte always sits in the top 8 bits of the shift register
                w_tx = r_shift[{2'b11, r_bit}];
                if (w_bit_end) begin
                    w_timer_n = '0;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_timer_n = '0;
                    if (r_byte_idx != 2'd3) begin
                        w_byte_idx_n = r_byte_idx + 2'd1;
                        w_shift_n    = {r_shift[23:0], 8'h00};
                        w_state_n    = S_START;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so the line lags the FSM by one clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit      <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_timer    <= w_timer_n;
            r_bit      <= w_bit_n;
            r_byte_idx <= w_byte_idx_n;
            r_shift    <= w_shift_n;
            r_tx       <= w_tx;
            r_busy     <= (r_state != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.nonce_valid && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.nonce_in;
    end

    assign bus.uart_tx    = r_tx;
    assign bus.busy       = r_busy;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_golden_nonce_uart_tx.sv
// ============================================================================
// Module   : tb_golden_nonce_uart_tx
// Brief    : Self-checking bench for golden_nonce_uart_tx (BAUD_DIV=4, FIFO_AW=2)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_golden_nonce_uart_tx;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    golden_nonce_uart_tx_if #(.FIFO_AW(2)) bus ();

    golden_nonce_uart_tx #(.BAUD_DIV(BD), .FIFO_AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  rx_bytes[$];
    int          rx_start[$];
    int          busy_runs[$];
    int          ferr = 0;
    int          maxcnt = 0;
    logic [31:0] burst [0:7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model: samples each bit at its midpoint, counted from the first low sample
    initial begin : g_monitor
        int         brun;
        int         mcnt;
        bit         mact;
        logic [7:0] mbyte;
        brun = 0; mcnt = 0; mact = 0; mbyte = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mact = 0; brun = 0; ferr = 0; maxcnt = 0;
                rx_bytes.delete(); rx_start.delete(); busy_runs.delete();
            end else begin
                if (bus.busy === 1'b1) brun++;
                else if (brun != 0) begin busy_runs.push_back(brun); brun = 0; end
                if (int'(bus.fifo_count) > maxcnt) maxcnt = int'(bus.fifo_count);
                if (!mact) begin
                    if (bus.uart_tx === 1'b0) begin
                        mact = 1; mcnt = 0; rx_start.push_back(cyc);
                    end
                end else mcnt++;
                if (mact && (mcnt % BD) == BD/2) begin
                    if (mcnt / BD == 0) begin
                        if (bus.uart_tx !== 1'b0) ferr++;
                    end else if (mcnt / BD <= 8) begin
                        mbyte[mcnt/BD - 1] = bus.uart_tx;
                    end else begin
                        if (bus.uart_tx !== 1'b1) ferr++;
                        rx_bytes.push_back(mbyte);
                        mact = 0;
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
    endtask

    task automatic send_burst(input int num, output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < num; i++) begin
            @(negedge clk);
            bus.nonce_valid = 1'b1;
            bus.nonce_in    = burst[i];
            if (i == 0) first_cyc = cyc + 1;
        end
        @(negedge clk);
        bus.nonce_valid = 1'b0;
    endtask

    task automatic chk_nonce(input string name, input int idx, input logic [31:0] n);
        chk({name, "_byte0"}, 64'(rx_bytes[idx*4+0]), 64'(n[31:24]));
        chk({name, "_byte1"}, 64'(rx_bytes[idx*4+1]), 64'(n[23:16]));
        chk({name, "_byte2"}, 64'(rx_bytes[idx*4+2]), 64'(n[15:8]));
        chk({name, "_byte3"}, 64'(rx_bytes[idx*4+3]), 64'(n[7:0]));
    endtask

    initial begin
        vec_t vecs [4];
        int   fc;
        int   bad;

        vecs[0] = '{32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        vecs[1] = '{32'h00000001, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'h80005A3C, 8'h80, 8'h00, 8'h5A, 8'h3C};

        bus.nonce_valid = 1'b0;
        bus.nonce_in    = '0;
        wait_cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx",       64'(bus.uart_tx),    64'd1);
        chk("reset_busy",     64'(bus.busy),       64'd0);
        chk("reset_count",    64'(bus.fifo_count), 64'd0);
        chk("reset_overflow", 64'(bus.overflow),   64'd0);

        // Single nonce into an idle block, table-driven
        for (int v = 0; v < 4; v++) begin
            do_reset();
            burst[0] = vecs[v].nonce;
            send_burst(1, fc);
            wait_cyc(200);
            chk("single_nbytes",  64'(rx_bytes.size()), 64'd4);
            chk("single_b0",      64'(rx_bytes[0]), 64'(vecs[v].b0));
            chk("single_b1",      64'(rx_bytes[1]), 64'(vecs[v].b1));
            chk("single_b2",      64'(rx_bytes[2]), 64'(vecs[v].b2));
            chk("single_b3",      64'(rx_bytes[3]), 64'(vecs[v].b3));
            chk("single_framing", 64'(ferr), 64'd0);
            chk("single_latency", 64'(rx_start[0] - fc), 64'd2);
            chk("single_busy_len", 64'(busy_runs[0]), 64'd160);
            chk("single_busy_cnt", 64'(busy_runs.size()), 64'd1);
        end

        // Three back-to-back strobes
        do_reset();
        burst[0] = 32'h11111111; burst[1] = 32'h22222222; burst[2] = 32'h33333333;
        send_burst(3, fc);
        wait_cyc(3 * 161 + 40);
        chk("three_maxcount", 64'(maxcnt), 64'd2);
        chk("three_nbytes",   64'(rx_bytes.size()), 64'd12);
        chk_nonce("three_n0", 0, 32'h11111111);
        chk_nonce("three_n1", 1, 32'h22222222);
        chk_nonce("three_n2", 2, 32'h33333333);
        for (int i = 1; i < 12; i++)
            chk("three_byte_gap", 64'(rx_start[i] - rx_start[i-1]), (i % 4 == 0) ? 64'd41 : 64'd40);
        chk("three_overflow", 64'(bus.overflow), 64'd0);
        chk("three_framing",  64'(ferr), 64'd0);

        // Six strobes: one in flight, four queued, one dropped
        do_reset();
        for (int i = 0; i < 6; i++) burst[i] = 32'h0A0B0C00 + i;
        send_burst(6, fc);
        chk("six_count_full", 64'(bus.fifo_count), 64'd4);
        chk("six_overflow",   64'(bus.overflow), 64'd1);
        wait_cyc(5 * 161 + 40);
        chk("six_nbytes",     64'(rx_bytes.size()), 64'd20);
        for (int i = 0; i < 5; i++) chk_nonce("six_n", i, 32'h0A0B0C00 + i);
        chk("six_overflow_sticky", 64'(bus.overflow), 64'd1);

        // Push on the IDLE pop edge with the FIFO full
        do_reset();
        for (int i = 0; i < 5; i++) burst[i] = 32'hC0DE0000 + i;
        send_burst(5, fc);
        bad = 0;
        while (cyc < fc + 161 && bad < 1000) begin @(negedge clk); bad++; end
        chk("popedge_pre_count", 64'(bus.fifo_count), 64'd4);
        bus.nonce_valid = 1'b1;
        bus.nonce_in    = 32'hBEEF1234;
        @(negedge clk);
        bus.nonce_valid = 1'b0;
        chk("popedge_cyc",      64'(cyc - fc), 64'd162);
        chk("popedge_count",    64'(bus.fifo_count), 64'd4);
        chk("popedge_overflow", 64'(bus.overflow), 64'd0);
        wait_cyc(5 * 161 + 40);
        chk("popedge_nbytes",   64'(rx_bytes.size()), 64'd24);
        chk_nonce("popedge_last", 5, 32'hBEEF1234);

        // Reset in the data bits of byte 2
        do_reset();
        burst[0] = 32'h00000000;
        for (int i = 1; i < 6; i++) burst[i] = 32'h55AA0000 + i;
        send_burst(6, fc);
        bad = 0;
        while (cyc < fc + 2 + 2*40 + 10 && bad < 1000) begin @(negedge clk); bad++; end
        chk("midreset_pre_tx",   64'(bus.uart_tx), 64'd0);
        chk("midreset_pre_ovf",  64'(bus.overflow), 64'd1);
        chk("midreset_pre_nb",   64'(rx_bytes.size()), 64'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_tx",       64'(bus.uart_tx), 64'd1);
        chk("midreset_busy",     64'(bus.busy), 64'd0);
        chk("midreset_count",    64'(bus.fifo_count), 64'd0);
        chk("midreset_overflow", 64'(bus.overflow), 64'd0);
        wait_cyc(2);
        reset = 1'b0;
        burst[0] = 32'h00000001;
        send_burst(1, fc);
        wait_cyc(200);
        chk("after_reset_nbytes", 64'(rx_bytes.size()), 64'd4);
        chk_nonce("after_reset", 0, 32'h00000001);
        chk("after_reset_framing", 64'(ferr), 64'd0);

        // Quiet line after reset
        do_reset();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("quiet_violations", 64'(bad), 64'd0);
        chk("quiet_nbytes",     64'(rx_bytes.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
